// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// dmem_responder_if : request/response channels of the data-memory port
// Revision 1.0
// ============================================================================
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : latency-configurable word memory behind a valid/ready port
// Revision 1.0
// ============================================================================
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  wire logic         clk_i,
  input  wire logic         rst_ni,
  dmem_responder_if.slave   bus,
  output logic              busy_o
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(LATENCY) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0] memory [0:DEPTH-1];

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          write_q, write_d;

  logic            accept;
  logic            commit;
  logic            access_err;
  logic            mem_we;
  logic [IDXW-1:0] idx;

  assign accept     = (state_q == S_IDLE) && bus.req_valid && req_ready_q;
  assign commit     = (state_q == S_WAIT) && (cnt_q == '0);
  assign access_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH));
  assign idx        = addr_q[IDXW+1:2];
  assign mem_we     = commit && write_q && !access_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
    end
  end

  // Array is deliberately left out of reset so preloaded contents survive it.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      memory[idx] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_WAIT;
      S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
      S_RESP:  if (bus.resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    busy_d       = busy_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          write_d     = bus.req_write;
          cnt_d       = CW'(LATENCY - 1);
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          resp_valid_d = 1'b1;
          err_d        = access_err;
          rdata_d      = (access_err || write_q) ? 32'h0 : memory[idx];
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          rdata_d      = '0;
          err_d        = 1'b0;
          req_ready_d  = 1'b1;
          busy_d       = 1'b0;
        end
      end
      default: begin
        req_ready_d = 1'b0;
      end
    endcase
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign busy_o         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder : directed self-checking bench for dmem_responder
// Revision 1.0
// ============================================================================
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   total = 0;
  int   bad = 0;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH(256), .LATENCY(3)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Runs one transaction; resp_ready is held low for 'hold' cycles in RESP
  // while req_valid toggles. viol counts cycles where WAIT/RESP invariants broke.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, output logic [31:0] rdata, output logic err,
                        output int lat, output int viol, output logic ready_back);
    int n;
    viol = 0; lat = -1; rdata = 'x; err = 1'bx; ready_back = 1'b0; n = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.resp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_write = ~wr; bus.req_addr = 32'h40; bus.req_wdata = 32'hA5A5A5A5;
    for (int c = 1; c <= 20; c++) begin
      if (bus.req_ready !== 1'b0 || busy !== 1'b1 || bus.resp_valid !== 1'b0) viol++;
      @(posedge clk); #1;
      if (bus.resp_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) return;
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = ~bus.req_valid;
      @(posedge clk); #1;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== rdata || bus.resp_err !== err ||
          bus.req_ready !== 1'b0 || busy !== 1'b1) viol++;
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    ready_back = (bus.req_ready === 1'b1) && (bus.resp_valid === 1'b0) && (busy === 1'b0) &&
                 (bus.resp_rdata === 32'h0) && (bus.resp_err === 1'b0);
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err, busy} !== 36'h0) begin
        bad++;
        $display("FAIL reset_outputs cycle=%0d got=%h want=0", i,
                 {bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err, busy});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release req_ready=%b busy=%b want req_ready=1 busy=0", bus.req_ready, busy);
    end
  endtask

  task automatic test_load();
    logic [31:0] rd; logic er; int lat, viol; logic rb;
    do_txn(1'b0, 32'h0C, 32'h0, 0, rd, er, lat, viol, rb);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL load_latency got=%0d want=3", lat); end
    total++;
    if (rd !== 32'd99 || er !== 1'b0) begin bad++; $display("FAIL load_data got=%h/%b want=63/0", rd, er); end
    total++;
    if (viol !== 0 || rb !== 1'b1) begin bad++; $display("FAIL load_handshake viol=%0d ready_back=%b want 0/1", viol, rb); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat, viol; logic rb;
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, viol, rb);
    total++;
    if (lat !== 3 || rd !== 32'h0 || er !== 1'b0 || viol !== 0 || rb !== 1'b1) begin
      bad++; $display("FAIL store_ack lat=%0d rdata=%h err=%b viol=%0d want 3/0/0/0", lat, rd, er, viol);
    end
    total++;
    if (dut.memory[4] !== 32'hDEADBEEF) begin bad++; $display("FAIL store_mem got=%h want=deadbeef", dut.memory[4]); end
    do_txn(1'b0, 32'h10, 32'h0, 0, rd, er, lat, viol, rb);
    total++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 3) begin
      bad++; $display("FAIL store_readback got=%h err=%b lat=%0d want=deadbeef/0/3", rd, er, lat);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat, viol; logic rb;
    do_txn(1'b0, 32'h0E, 32'h0, 0, rd, er, lat, viol, rb);
    total++;
    if (rd !== 32'h0 || er !== 1'b1 || lat !== 3) begin bad++; $display("FAIL err_misaligned_load got=%h/%b want=0/1", rd, er); end
    do_txn(1'b0, 32'h400, 32'h0, 0, rd, er, lat, viol, rb);
    total++;
    if (rd !== 32'h0 || er !== 1'b1 || rb !== 1'b1) begin bad++; $display("FAIL err_range_load got=%h/%b want=0/1", rd, er); end
    do_txn(1'b1, 32'h0E, 32'h11111111, 0, rd, er, lat, viol, rb);
    total++;
    if (er !== 1'b1 || dut.memory[3] !== 32'd99) begin
      bad++; $display("FAIL err_misaligned_store err=%b mem3=%h want 1/63", er, dut.memory[3]);
    end
    do_txn(1'b1, 32'h400, 32'h22222222, 0, rd, er, lat, viol, rb);
    total++;
    if (er !== 1'b1 || rd !== 32'h0 || dut.memory[0] !== 32'h0BADF00D) begin
      bad++; $display("FAIL err_range_store err=%b rdata=%h mem0=%h want 1/0/0badf00d", er, rd, dut.memory[0]);
    end
  endtask

  task automatic test_hold();
    logic [31:0] rd; logic er; int lat, viol; logic rb;
    do_txn(1'b0, 32'h14, 32'h0, 5, rd, er, lat, viol, rb);
    total++;
    if (rd !== 32'h55551234 || er !== 1'b0 || lat !== 3) begin bad++; $display("FAIL hold_data got=%h/%b want=55551234/0", rd, er); end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL hold_stable violations=%0d want=0", viol); end
    total++;
    if (rb !== 1'b1) begin bad++; $display("FAIL hold_release ready_back=%b want=1", rb); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat, viol; logic rb; int n;
    n = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'h12345678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || bus.req_ready !== 1'b0) begin bad++; $display("FAIL midreset_outputs busy=%b ready=%b want 0/0", busy, bus.req_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (dut.memory[8] !== 32'd7) begin bad++; $display("FAIL midreset_mem got=%h want=7", dut.memory[8]); end
    total++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL midreset_idle ready=%b busy=%b want 1/0", bus.req_ready, busy); end
    do_txn(1'b0, 32'h20, 32'h0, 0, rd, er, lat, viol, rb);
    total++;
    if (rd !== 32'd7 || lat !== 3) begin bad++; $display("FAIL midreset_load got=%h lat=%0d want=7/3", rd, lat); end
    do_txn(1'b1, 32'h24, 32'hCAFE0001, 0, rd, er, lat, viol, rb);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if (dut.memory[9] !== 32'hCAFE0001) begin bad++; $display("FAIL committed_store got=%h want=cafe0001", dut.memory[9]); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b0;
    dut.memory[0] = 32'h0BADF00D;
    dut.memory[3] = 32'd99;
    dut.memory[5] = 32'h55551234;
    dut.memory[8] = 32'd7;
    dut.memory[9] = 32'h0;
    test_reset();
    test_load();
    test_store_load();
    test_errors();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
